i2c_write_byte: RTL
===================

# i2c_write_byte

Byte-level transmitter that sits directly upstream of the I2C bit writer. It accepts one data word plus optional START/STOP framing from the controller. It issues the matching sequence of single-bit commands (START, DATA_0/DATA_1 MSB first, STOP) over the bit writer's `command`/`go`/`finish` handshake, and reports completion with a one-cycle `finish` pulse.

## Interface
- `DATA_WIDTH`, default 8: bits per word, minimum 1.
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high; forces all state and outputs to reset values immediately.
- `go`  in  1: request from the controller; sampled only in IDLE with `finish` low.
- `data_in`  in  DATA_WIDTH: word to send; latched when `go` is accepted.
- `with_start`  in  1: prepend START_BIT; latched when `go` is accepted.
- `with_stop`  in  1: append STOP_BIT; latched when `go` is accepted.
- `finish`  out  1: registered; high for exactly one cycle when the sequence completes.
- `busy`  out  1: registered; high from the accept edge until the edge that raises `finish`.
- `bit_command`  out  3: command to the bit writer; 3'b000 idle, 3'b010 START, 3'b011 STOP, 3'b100 DATA_0, 3'b101 DATA_1.
- `bit_go`  out  1: registered request to the bit writer.
- `bit_finish`  in  1: completion from the bit writer.

## Operation
- States:
  - IDLE: waiting for a request.
  - ISSUE: `bit_go` high, waiting for `bit_finish`.
  - GAP: `bit_go` low for one cycle.
  - DONE: `finish` high.
- IDLE, `go`=1 and `finish`=0 at an edge (accept edge):
  - Latch `data_in` into the shift register, and latch `with_start`/`with_stop`.
  - Load the step count N = DATA_WIDTH + with_start + with_stop.
  - Drive the first step's command, set `bit_go`=1 and `busy`=1, and enter ISSUE.
- Step order: START (if latched), data bits MSB first (bit 1 → 3'b101, bit 0 → 3'b100), then STOP (if latched).
- ISSUE, `bit_finish`=1 at an edge:
  - Set `bit_go` to 0 and decrement the remaining-step count.
  - Shift the register if the finished step was a data bit.
  - If steps remain, go to GAP. Otherwise set `finish`=1 and `busy`=0, and go to DONE.
- GAP, next edge: drive the next step's command, set `bit_go`=1, and go to ISSUE.
- DONE, next edge: set `finish`=0, set `bit_command`=3'b000, and go to IDLE.
- `bit_command` is stable for the whole time `bit_go` is high. It holds its last value through GAP and is 3'b000 in IDLE.
- Ignored inputs:
  - `bit_finish` outside ISSUE.
  - `go` outside IDLE; dropping `go` mid-sequence does not abort.
  - Changes to `data_in`/`with_*` after the accept edge.
- Caller contract: drop `go` on the edge at which `finish`=1 is sampled. If `go` is still high in IDLE after `finish` falls, a new sequence is accepted (back-to-back operation).
- Reset asserted in any state: state IDLE; `finish`=0, `busy`=0, `bit_go`=0, `bit_command`=3'b000; shift register and step count cleared. The bit writer shares the reset and returns to IDLE together with this block.

## Timing
- Reset values: `finish` 0, `busy` 0, `bit_go` 0, `bit_command` 3'b000.
- `bit_go` rises on the accept edge; there is no extra load cycle.
- Each `bit_go` high period ends on the edge that samples `bit_finish`=1. One low cycle (GAP) follows before the next step, so the bit writer sees `go` low and clears its counter.
- With the standard bit writer (`finish` at its counter value 4), each step occupies 6 cycles: 5 with `bit_go` high and 1 low.
- `finish` rises 6N−1 cycles after the accept edge:
  - 8 bits, no framing: 47 cycles.
  - 8 bits, START and STOP: 59 cycles.
- Earliest next accept edge: the edge after `finish` falls, i.e. 6N+1 cycles after the previous accept edge.

## Test plan
- Reset: assert `reset` mid-cycle in IDLE, then deassert → all outputs at reset values immediately and no `bit_go` activity.
- Plain byte: `data_in`=8'hA5, `with_start`=0, `with_stop`=0, `go` pulse, bit-writer model in loop → `bit_command` sequence 101,100,101,100,100,101,100,101; `bit_go` high 5 / low 1 cycles per step; `finish` one cycle at accept+47.
- Framed byte: `data_in`=8'h00, `with_start`=1, `with_stop`=1 → commands 010, eight of 100, then 011; `finish` at accept+59; `busy` high for exactly 59 cycles.
- Input isolation: change `data_in` to 8'hFF and drop `go` 3 cycles after accept with `data_in`=8'h81 → commands still encode 8'h81; `finish` still arrives.
- Back-to-back: hold `go` high with `data_in`=8'h3C, then 8'hC3 → second accept on the edge after `finish` falls; second sequence encodes 8'hC3; no spurious `bit_go` during DONE.
- Reset mid-sequence: assert `reset` during the 4th data step → `bit_go`=0, `bit_command`=000, `busy`=0 immediately; after release, a new request `data_in`=8'h01 completes correctly at accept+47.

Source files
------------

// File: rtl/i2c_write_byte.sv
// Byte transmitter feeding the I2C bit writer: turns one word plus optional
// START/STOP framing into a sequence of single-bit commands.
module i2c_write_byte #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  with_start,
  input  logic                  with_stop,
  output logic                  finish,
  output logic                  busy,
  output logic [2:0]            bit_command,
  output logic                  bit_go,
  input  logic                  bit_finish
);

  localparam int CW = $clog2(DATA_WIDTH + 3);

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_START = 3'b010;
  localparam logic [2:0] CMD_STOP  = 3'b011;
  localparam logic [2:0] CMD_D0    = 3'b100;
  localparam logic [2:0] CMD_D1    = 3'b101;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         steps_q, steps_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  finish_d, busy_d, bit_go_d;
  logic [2:0]            cmd_d, nxt_cmd;

  // Command for the step after the current one; START is pending until it
  // completes, and data bits remain while steps exceed the pending STOP.
  always_comb begin
    nxt_cmd = CMD_STOP;
    if (start_q)
      nxt_cmd = CMD_START;
    else if (steps_q > CW'(stop_q))
      nxt_cmd = shreg_q[DATA_WIDTH-1] ? CMD_D1 : CMD_D0;
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    steps_d  = steps_q;
    start_d  = start_q;
    stop_d   = stop_q;
    finish_d = finish;
    busy_d   = busy;
    bit_go_d = bit_go;
    cmd_d    = bit_command;
    case (state_q)
      IDLE: begin
        if (go && !finish) begin
          shreg_d  = data_in;
          start_d  = with_start;
          stop_d   = with_stop;
          steps_d  = CW'(DATA_WIDTH) + CW'(with_start) + CW'(with_stop);
          cmd_d    = with_start ? CMD_START
                   : (data_in[DATA_WIDTH-1] ? CMD_D1 : CMD_D0);
          bit_go_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (bit_finish) begin
          bit_go_d = 1'b0;
          steps_d  = steps_q - CW'(1);
          if (bit_command[2])
            shreg_d = shreg_q << 1;
          if (bit_command == CMD_START)
            start_d = 1'b0;
          if (steps_q == CW'(1)) begin
            finish_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = DONE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        cmd_d    = nxt_cmd;
        bit_go_d = 1'b1;
        state_d  = ISSUE;
      end
      DONE: begin
        finish_d = 1'b0;
        cmd_d    = CMD_IDLE;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      steps_q     <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      finish      <= 1'b0;
      busy        <= 1'b0;
      bit_go      <= 1'b0;
      bit_command <= CMD_IDLE;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      steps_q     <= steps_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      finish      <= finish_d;
      busy        <= busy_d;
      bit_go      <= bit_go_d;
      bit_command <= cmd_d;
    end
  end

endmodule
